// File: rtl/nvdla_csb_arb2_if.sv
// Bundle of every handshake/bus signal around the two-requester CSB arbiter:
// both requester links, the shared NVDLA CSB target port and the timeout flag.
interface nvdla_csb_arb2_if;
    // Requester 0 (host APB bridge)
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_addr;
    logic [31:0] req0_wdat;
    logic        req0_write;
    logic        req0_nposted;
    logic        rsp0_valid;
    logic [31:0] rsp0_data;
    // Requester 1 (on-chip config sequencer)
    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_addr;
    logic [31:0] req1_wdat;
    logic        req1_write;
    logic        req1_nposted;
    logic        rsp1_valid;
    logic [31:0] rsp1_data;
    // Shared NVDLA CSB target port
    logic        csb2nvdla_valid;
    logic        csb2nvdla_ready;
    logic [15:0] csb2nvdla_addr;
    logic [31:0] csb2nvdla_wdat;
    logic        csb2nvdla_write;
    logic        csb2nvdla_nposted;
    logic        nvdla2csb_valid;
    logic [31:0] nvdla2csb_data;
    logic        nvdla2csb_wr_complete;
    // Timeout status
    logic        tmo_err;
    logic        tmo_clr;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_addr, req0_wdat, req0_write, req0_nposted,
        input  req1_valid, req1_addr, req1_wdat, req1_write, req1_nposted,
        input  csb2nvdla_ready, nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete,
        input  tmo_clr,
        output req0_ready, rsp0_valid, rsp0_data,
        output req1_ready, rsp1_valid, rsp1_data,
        output csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write,
        output csb2nvdla_nposted, tmo_err
    );

    // Environment side: requesters plus the NVDLA target
    modport master (
        output req0_valid, req0_addr, req0_wdat, req0_write, req0_nposted,
        output req1_valid, req1_addr, req1_wdat, req1_write, req1_nposted,
        output csb2nvdla_ready, nvdla2csb_valid, nvdla2csb_data, nvdla2csb_wr_complete,
        output tmo_clr,
        input  req0_ready, rsp0_valid, rsp0_data,
        input  req1_ready, rsp1_valid, rsp1_data,
        input  csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write,
        input  csb2nvdla_nposted, tmo_err
    );
endinterface

// File: rtl/nvdla_csb_arb2.sv
// Round-robin arbiter sharing one NVDLA CSB target port between two requesters.
// At most one read or non-posted write is outstanding; its response is routed
// back to the issuing requester, and a missing response is replaced by an
// all-ones timeout response after TMO_CYCLES cycles.
module nvdla_csb_arb2 #(
    parameter int unsigned TMO_CYCLES = 1023  // 1..1023
) (
    input logic              pclk,
    input logic              prstn,
    nvdla_csb_arb2_if.slave  bus
);

    localparam logic [9:0] CntLast = 10'(TMO_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StRdWait, StWrWait} state_e;

    state_e      state_q;
    logic        prio_q;
    logic        lock_q;
    logic        lock_id_q;
    logic        owner_q;
    logic [9:0]  cnt_q;
    logic        tmo_err_q;

    logic        grant;
    logic        grant_valid;
    logic        csb_valid;
    logic        accept;
    logic        rsp_hit;
    logic        tmo_hit;
    logic        rsp_fire;
    logic [31:0] rsp_word;

    // Grant select: a stalled grant is pinned, otherwise round-robin on contention
    always_comb begin
        grant = 1'b0;
        if (lock_q) begin
            grant = lock_id_q;
        end else if (bus.req0_valid && bus.req1_valid) begin
            grant = prio_q;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    assign grant_valid = grant ? bus.req1_valid : bus.req0_valid;
    assign csb_valid   = grant_valid && (state_q == StIdle);
    assign accept      = csb_valid && bus.csb2nvdla_ready;

    // Downstream mux driven from the granted requester
    always_comb begin
        bus.csb2nvdla_valid   = csb_valid;
        bus.csb2nvdla_addr    = grant ? bus.req1_addr    : bus.req0_addr;
        bus.csb2nvdla_wdat    = grant ? bus.req1_wdat    : bus.req0_wdat;
        bus.csb2nvdla_write   = grant ? bus.req1_write   : bus.req0_write;
        bus.csb2nvdla_nposted = grant ? bus.req1_nposted : bus.req0_nposted;
        bus.req0_ready        = accept && !grant;
        bus.req1_ready        = accept && grant;
    end

    // Responses only count in the matching wait state; anything else is stray
    assign rsp_hit  = ((state_q == StRdWait) && bus.nvdla2csb_valid) ||
                      ((state_q == StWrWait) && bus.nvdla2csb_wr_complete);
    assign tmo_hit  = (state_q != StIdle) && !rsp_hit && (cnt_q == CntLast);
    assign rsp_fire = rsp_hit || tmo_hit;

    // Response routing; idle data lanes pass nvdla2csb_data straight through
    always_comb begin
        rsp_word = 32'h0;
        if (tmo_hit) begin
            rsp_word = 32'hFFFF_FFFF;
        end else if (state_q == StRdWait) begin
            rsp_word = bus.nvdla2csb_data;
        end
        bus.rsp0_valid = rsp_fire && !owner_q;
        bus.rsp1_valid = rsp_fire && owner_q;
        bus.rsp0_data  = bus.rsp0_valid ? rsp_word : bus.nvdla2csb_data;
        bus.rsp1_data  = bus.rsp1_valid ? rsp_word : bus.nvdla2csb_data;
        bus.tmo_err    = tmo_err_q;
    end

    // Transaction FSM with arbitration state, wait counter and sticky timeout flag
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state_q   <= StIdle;
            prio_q    <= 1'b0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            owner_q   <= 1'b0;
            cnt_q     <= 10'd0;
            tmo_err_q <= 1'b0;
        end else begin
            // Setting on a timeout beats a simultaneous clear
            if (tmo_hit) begin
                tmo_err_q <= 1'b1;
            end else if (bus.tmo_clr) begin
                tmo_err_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (csb_valid && !bus.csb2nvdla_ready) begin
                        lock_q    <= 1'b1;
                        lock_id_q <= grant;
                    end
                    if (accept) begin
                        lock_q <= 1'b0;
                        prio_q <= ~grant;
                        // Posted writes expect no response and stay in idle
                        if (!bus.csb2nvdla_write || bus.csb2nvdla_nposted) begin
                            owner_q <= grant;
                            cnt_q   <= 10'd0;
                            state_q <= bus.csb2nvdla_write ? StWrWait : StRdWait;
                        end
                    end
                end
                StRdWait, StWrWait: begin
                    if (rsp_fire) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_nvdla_csb_arb2.sv
// Directed bench for nvdla_csb_arb2: a per-cycle vector table for arbitration
// plus hand-written sequences for reads, lock, non-posted writes, timeout, reset.
module tb_nvdla_csb_arb2;

    localparam logic [15:0] A0 = 16'h0010;
    localparam logic [15:0] A1 = 16'h0020;
    localparam logic [31:0] W0 = 32'hA0A0_0000;
    localparam logic [31:0] W1 = 32'hB1B1_0000;

    logic pclk;
    logic prstn;
    int   n_tests;
    int   n_fail;

    nvdla_csb_arb2_if bus ();
    nvdla_csb_arb2_if bus8 ();

    // Default-timeout DUT and a short-timeout DUT fed identical stimulus
    nvdla_csb_arb2 dut (
        .pclk  (pclk),
        .prstn (prstn),
        .bus   (bus.slave)
    );

    nvdla_csb_arb2 #(.TMO_CYCLES(8)) dut8 (
        .pclk  (pclk),
        .prstn (prstn),
        .bus   (bus8.slave)
    );

    assign bus8.req0_valid            = bus.req0_valid;
    assign bus8.req0_addr             = bus.req0_addr;
    assign bus8.req0_wdat             = bus.req0_wdat;
    assign bus8.req0_write            = bus.req0_write;
    assign bus8.req0_nposted          = bus.req0_nposted;
    assign bus8.req1_valid            = bus.req1_valid;
    assign bus8.req1_addr             = bus.req1_addr;
    assign bus8.req1_wdat             = bus.req1_wdat;
    assign bus8.req1_write            = bus.req1_write;
    assign bus8.req1_nposted          = bus.req1_nposted;
    assign bus8.csb2nvdla_ready       = bus.csb2nvdla_ready;
    assign bus8.nvdla2csb_valid       = bus.nvdla2csb_valid;
    assign bus8.nvdla2csb_data        = bus.nvdla2csb_data;
    assign bus8.nvdla2csb_wr_complete = bus.nvdla2csb_wr_complete;
    assign bus8.tmo_clr               = bus.tmo_clr;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct packed {
        logic r0v, r1v, rdy, nvv, nvwc;
        logic e_cv, e_gnt, e_r0r, e_r1r, e_s0, e_s1;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_addr = A0; bus.req0_wdat = W0;
        bus.req0_write = 1'b1; bus.req0_nposted = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_addr = A1; bus.req1_wdat = W1;
        bus.req1_write = 1'b1; bus.req1_nposted = 1'b0;
        bus.csb2nvdla_ready = 1'b1;
        bus.nvdla2csb_valid = 1'b0;
        bus.nvdla2csb_data = 32'h0BAD_0001;
        bus.nvdla2csb_wr_complete = 1'b0;
        bus.tmo_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        prstn = 1'b0;
        tick();
        tick();
        prstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        prstn   = 1'b1;
        idle_inputs();

        //             r0v  r1v  rdy  nvv  nvwc e_cv e_gnt r0r  r1r  s0   s1
        tbl[0]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
        tbl[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0};
        tbl[6]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[9]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0};
        tbl[10] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};

        // Posted-write arbitration table, starting from reset
        do_reset();
        #3;
        chk("reset_tmo_err", 32'(bus.tmo_err), 32'd0);
        for (int i = 0; i < 11; i++) begin
            bus.req0_valid            = tbl[i].r0v;
            bus.req1_valid            = tbl[i].r1v;
            bus.csb2nvdla_ready       = tbl[i].rdy;
            bus.nvdla2csb_valid       = tbl[i].nvv;
            bus.nvdla2csb_wr_complete = tbl[i].nvwc;
            #3;
            chk($sformatf("v%0d_cvalid", i), 32'(bus.csb2nvdla_valid), 32'(tbl[i].e_cv));
            chk($sformatf("v%0d_addr", i), 32'(bus.csb2nvdla_addr),
                32'(tbl[i].e_gnt ? A1 : A0));
            chk($sformatf("v%0d_wdat", i), bus.csb2nvdla_wdat, tbl[i].e_gnt ? W1 : W0);
            chk($sformatf("v%0d_r0rdy", i), 32'(bus.req0_ready), 32'(tbl[i].e_r0r));
            chk($sformatf("v%0d_r1rdy", i), 32'(bus.req1_ready), 32'(tbl[i].e_r1r));
            chk($sformatf("v%0d_rsp0v", i), 32'(bus.rsp0_valid), 32'(tbl[i].e_s0));
            chk($sformatf("v%0d_rsp1v", i), 32'(bus.rsp1_valid), 32'(tbl[i].e_s1));
            tick();
        end

        // Read from req0 while req1 waits; response three cycles later
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 16'h0123;
        bus.req1_valid = 1'b1;
        #3;
        chk("rd_cvalid", 32'(bus.csb2nvdla_valid), 32'd1);
        chk("rd_addr", 32'(bus.csb2nvdla_addr), 32'h0123);
        chk("rd_write", 32'(bus.csb2nvdla_write), 32'd0);
        chk("rd_r0rdy", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        for (int k = 1; k < 3; k++) begin
            #3;
            chk($sformatf("rd_wait%0d_cvalid", k), 32'(bus.csb2nvdla_valid), 32'd0);
            chk($sformatf("rd_wait%0d_r1rdy", k), 32'(bus.req1_ready), 32'd0);
            chk($sformatf("rd_wait%0d_rsp0v", k), 32'(bus.rsp0_valid), 32'd0);
            chk($sformatf("rd_wait%0d_pass", k), bus.rsp0_data, 32'h0BAD_0001);
            tick();
        end
        bus.nvdla2csb_valid = 1'b1; bus.nvdla2csb_data = 32'hCAFE_F00D;
        #3;
        chk("rd_rsp0v", 32'(bus.rsp0_valid), 32'd1);
        chk("rd_rsp0d", bus.rsp0_data, 32'hCAFE_F00D);
        chk("rd_rsp1v", 32'(bus.rsp1_valid), 32'd0);
        chk("rd_rsp_cvalid", 32'(bus.csb2nvdla_valid), 32'd0);
        tick();
        bus.nvdla2csb_valid = 1'b0;
        #3;
        chk("rd_next_cvalid", 32'(bus.csb2nvdla_valid), 32'd1);
        chk("rd_next_addr", 32'(bus.csb2nvdla_addr), 32'(A1));
        chk("rd_next_r1rdy", 32'(bus.req1_ready), 32'd1);
        tick();

        // Stalled grant on req0 is held even though req1 gains priority
        do_reset();
        bus.req0_valid = 1'b1;
        tick();                             // posted write from req0 -> prio=1
        bus.csb2nvdla_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k >= 1) bus.req1_valid = 1'b1;
            #3;
            chk($sformatf("lk%0d_cvalid", k), 32'(bus.csb2nvdla_valid), 32'd1);
            chk($sformatf("lk%0d_addr", k), 32'(bus.csb2nvdla_addr), 32'(A0));
            chk($sformatf("lk%0d_r1rdy", k), 32'(bus.req1_ready), 32'd0);
            tick();
        end
        bus.csb2nvdla_ready = 1'b1;
        #3;
        chk("lk_acc_r0rdy", 32'(bus.req0_ready), 32'd1);
        chk("lk_acc_addr", 32'(bus.csb2nvdla_addr), 32'(A0));
        tick();
        bus.req0_valid = 1'b0;
        #3;
        chk("lk_next_r1rdy", 32'(bus.req1_ready), 32'd1);
        tick();

        // Non-posted write from req1, completion ten cycles after acceptance
        do_reset();
        bus.req1_valid = 1'b1; bus.req1_nposted = 1'b1;
        #3;
        chk("np_r1rdy", 32'(bus.req1_ready), 32'd1);
        chk("np_nposted", 32'(bus.csb2nvdla_nposted), 32'd1);
        tick();
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1;              // must wait until WR_WAIT ends
        for (int k = 1; k < 10; k++) begin
            #3;
            chk($sformatf("np_wait%0d_rsp1v", k), 32'(bus.rsp1_valid), 32'd0);
            chk($sformatf("np_wait%0d_cvalid", k), 32'(bus.csb2nvdla_valid), 32'd0);
            tick();
        end
        bus.nvdla2csb_wr_complete = 1'b1; bus.nvdla2csb_data = 32'h0000_0055;
        #3;
        chk("np_rsp1v", 32'(bus.rsp1_valid), 32'd1);
        chk("np_rsp1d", bus.rsp1_data, 32'd0);
        chk("np_rsp0v", 32'(bus.rsp0_valid), 32'd0);
        tick();
        bus.nvdla2csb_wr_complete = 1'b0;
        #3;
        chk("np_idle_cvalid", 32'(bus.csb2nvdla_valid), 32'd1);
        chk("np_idle_r0rdy", 32'(bus.req0_ready), 32'd1);
        tick();

        // Timeout on the TMO_CYCLES=8 instance
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_write = 1'b0;
        #3;
        chk("to_r0rdy", 32'(bus8.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        for (int k = 1; k < 8; k++) begin
            #3;
            chk($sformatf("to_wait%0d_rsp0v", k), 32'(bus8.rsp0_valid), 32'd0);
            tick();
        end
        #3;
        chk("to_rsp0v", 32'(bus8.rsp0_valid), 32'd1);
        chk("to_rsp0d", bus8.rsp0_data, 32'hFFFF_FFFF);
        chk("to_err_pre", 32'(bus8.tmo_err), 32'd0);
        tick();
        bus.nvdla2csb_valid = 1'b1; bus.nvdla2csb_data = 32'h1234_5678;
        #3;
        chk("to_err_set", 32'(bus8.tmo_err), 32'd1);
        chk("to_late_rsp0v", 32'(bus8.rsp0_valid), 32'd0);
        chk("to_late_rsp1v", 32'(bus8.rsp1_valid), 32'd0);
        chk("to_main_err", 32'(bus.tmo_err), 32'd0);
        tick();
        bus.nvdla2csb_valid = 1'b0;
        bus.tmo_clr = 1'b1;
        #3;
        chk("to_err_sticky", 32'(bus8.tmo_err), 32'd1);
        tick();
        bus.tmo_clr = 1'b0;
        #3;
        chk("to_err_clr", 32'(bus8.tmo_err), 32'd0);
        tick();

        // Asynchronous reset while a read is outstanding
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_write = 1'b0;
        tick();                             // accepted, prio=1
        bus.req0_valid = 1'b0;
        bus.nvdla2csb_valid = 1'b1; bus.nvdla2csb_data = 32'h7777_0000;
        #1;
        chk("rst_pre_rsp0v", 32'(bus.rsp0_valid), 32'd1);
        #1;
        prstn = 1'b0;
        #1;
        chk("rst_async_rsp0v", 32'(bus.rsp0_valid), 32'd0);
        tick();
        tick();
        prstn = 1'b1;
        #3;
        chk("rst_after_rsp0v", 32'(bus.rsp0_valid), 32'd0);
        chk("rst_after_rsp1v", 32'(bus.rsp1_valid), 32'd0);
        tick();
        bus.nvdla2csb_valid = 1'b0;
        bus.req0_write = 1'b1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #3;
        chk("rst_prio_r0rdy", 32'(bus.req0_ready), 32'd1);
        chk("rst_prio_addr", 32'(bus.csb2nvdla_addr), 32'(A0));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nvdla_csb_arb2.md
# nvdla_csb_arb2

Two-requester arbiter sharing the single NVDLA CSB target port. It sits between two CSB-style masters and the `csb2nvdla_*`/`nvdla2csb_*` port: requester 0 is the host APB bridge and requester 1 is the on-chip config sequencer. Grants are round-robin and held until the downstream accepts. The block tracks at most one outstanding read or non-posted write, routes its response back to the issuing requester, and bounds the wait with a timeout.

## Interface
- `TMO_CYCLES`, default 1023: response-wait limit in cycles, range 1..1023 (10-bit counter).
- `pclk`  in  1  clock.
- `prstn`  in  1  reset; one clock, asynchronous, active-low.
- `req0_valid`/`req1_valid`  in  1  request valid per requester.
- `req0_ready`/`req1_ready`  out  1  request accepted.
- `req0_addr`/`req1_addr`  in  16  word address.
- `req0_wdat`/`req1_wdat`  in  32  write data.
- `req0_write`/`req1_write`  in  1  1 means write.
- `req0_nposted`/`req1_nposted`  in  1  write waits for completion.
- `rsp0_valid`/`rsp1_valid`  out  1  read data or write completion returned.
- `rsp0_data`/`rsp1_data`  out  32  read data.
- `csb2nvdla_valid`/`csb2nvdla_ready`  out/in  1  downstream handshake.
- `csb2nvdla_addr`  out  16  address to the NVDLA CSB port.
- `csb2nvdla_wdat`  out  32  write data to the NVDLA CSB port.
- `csb2nvdla_write`  out  1  write flag to the NVDLA CSB port.
- `csb2nvdla_nposted`  out  1  non-posted flag to the NVDLA CSB port.
- `nvdla2csb_valid`  in  1  read response valid.
- `nvdla2csb_data`  in  32  read response data.
- `nvdla2csb_wr_complete`  in  1  non-posted write completion.
- `tmo_err`  out  1  sticky timeout flag.
- `tmo_clr`  in  1  clears `tmo_err`.

## Operation
- States:
  - IDLE: arbitrate and issue.
  - RD_WAIT: read outstanding.
  - WR_WAIT: non-posted write outstanding.
- Registers:
  - `prio` (1b): preferred requester.
  - `lock` (1b), `lock_id` (1b): pending grant.
  - `owner` (1b): requester of the outstanding transaction.
  - `cnt` (10b): wait counter.
  - `tmo_err`.
- Arbitration, IDLE only:
  - If `lock` is set, grant `lock_id`.
  - Otherwise grant the single valid requester.
  - If both are valid, grant `prio`.
- Downstream mux: `csb2nvdla_*` drive the granted requester's fields. `csb2nvdla_valid` = granted `req_valid` & (state==IDLE).
- Ready: `reqN_ready` = `csb2nvdla_ready` & `csb2nvdla_valid` & (grant==N). The other requester sees ready 0.
- Grant hold: if `csb2nvdla_valid` & ~`csb2nvdla_ready`, set `lock`=1 and `lock_id`=grant. This prevents a grant switch under a pending valid. Clear `lock` on acceptance.
- On acceptance:
  - Set `prio` = ~grant.
  - Read: go to RD_WAIT, `owner`=grant, `cnt`=0.
  - Write with nposted=1: go to WR_WAIT, same register updates.
  - Posted write: stay in IDLE. No response is returned.
- RD_WAIT:
  - `nvdla2csb_valid` drives `rsp[owner]_valid`=1 in the same cycle, with `rsp[owner]_data`=`nvdla2csb_data`. Next state is IDLE.
  - Otherwise `cnt`++.
  - When `cnt`==`TMO_CYCLES-1` with no response: pulse `rsp[owner]_valid` with data 32'hFFFF_FFFF, set `tmo_err`, go to IDLE.
- WR_WAIT: identical to RD_WAIT, with `nvdla2csb_wr_complete` as the response. `rsp_data`=0 on completion; timeout data is 32'hFFFF_FFFF.
- Both `rsp_data` outputs carry `nvdla2csb_data` whenever their `rsp_valid` is 0. Consumers sample data only with valid.
- Stray responses: `nvdla2csb_valid` or `wr_complete` in IDLE, or late after a timeout, is dropped. Neither `rsp_valid` asserts.
- `tmo_err` is sticky until a cycle with `tmo_clr`=1. If a timeout and `tmo_clr` occur in the same cycle, the set wins.

## Timing
- Reset values: state=IDLE, `prio`=0, `lock`=0, `owner`=0, `cnt`=0, `tmo_err`=0.
  - Hence during and after reset `rsp*_valid`=0 and `req*_ready` follows `csb2nvdla_ready`.
- Issue latency is zero cycles: request to `csb2nvdla_valid` is combinational in IDLE.
- Response latency is zero cycles: `nvdla2csb_valid` to `rsp_valid` is combinational.
- The first new issue after a response is the next cycle, so there is one idle cycle minimum between a read response and the next issue.
- Posted writes stream back-to-back, one per cycle. Requesters alternate if both are valid.
- A timeout response fires exactly `TMO_CYCLES` cycles after acceptance when no response arrives.
- Reset mid-transaction: everything returns to reset values immediately. Any outstanding response is lost, and any later response is dropped as stray.

## Test plan
- Both requesters issue posted writes continuously with ready=1 -> grants alternate 0,1,0,1 on consecutive cycles, starting with 0 after reset.
- req0 read to addr 0x0123 while req1 is valid, ready=1, response 0xCAFEF00D three cycles later -> req1 is not granted during RD_WAIT. `rsp0_valid` pulses with 0xCAFEF00D; req1 is granted the cycle after.
- `csb2nvdla_ready`=0 for 4 cycles with req0 valid, then req1 asserts with req1 higher `prio` -> the grant stays on req0 until accepted, then req1 is granted.
- Non-posted write from req1, `wr_complete` after 10 cycles -> `rsp1_valid` pulses in that cycle. State returns to IDLE.
- `TMO_CYCLES`=8, read with no response -> `rsp_valid` with 0xFFFF_FFFF 8 cycles after acceptance and `tmo_err`=1. A late `nvdla2csb_valid` is dropped; `tmo_clr` clears the flag.
- `prstn` low during RD_WAIT, then a response arrives after release -> no `rsp_valid`; state is IDLE and `prio`=0.
